// File: rtl/qif_neuron_array.sv
// rtl/qif_neuron_array.sv - time-multiplexed array of quadratic integrate-and-fire neurons
//
// One shared datapath updates N_CH neuron channels, one channel per clock,
// each time a sweep is started with `step`. Each channel has its own drive
// input, and a refractory counter that freezes the channel after a spike.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   step       start one update sweep (accepted only while idle)
//   B          packed signed drive, channel i at [i*W +: W]
//   busy       high while a sweep is in progress
//   done       one-cycle pulse when a sweep completes
//   V          packed signed membrane potentials, registered
//   spike_out  per-channel spike flags from the last completed sweep

module qif_neuron_array #(
   parameter int N_CH    = 4,
   parameter int W       = 8,
   parameter int SHIFT   = 3,
   parameter int V_PEAK  = 64,
   parameter int V_RESET = -16,
   parameter int REFRAC  = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              step,
   input  logic [N_CH*W-1:0] B,
   output logic              busy,
   output logic              done,
   output logic [N_CH*W-1:0] V,
   output logic [N_CH-1:0]   spike_out
);

   localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
   // Full-precision width: V*V needs 2W bits, plus headroom for the two adds.
   localparam int FW = 2 * W + 2;

   localparam logic signed [FW-1:0] PEAK_F = FW'(V_PEAK);
   localparam logic signed [FW-1:0] MAX_F  = FW'((2 ** (W - 1)) - 1);
   localparam logic signed [FW-1:0] MIN_F  = FW'(-(2 ** (W - 1)));
   localparam logic [W-1:0]         RESET_V = W'(V_RESET);
   localparam logic [W-1:0]         MAX_V   = W'((2 ** (W - 1)) - 1);
   localparam logic [W-1:0]         MIN_V   = W'(-(2 ** (W - 1)));
   localparam logic [RW-1:0]        REFRAC_V = RW'(REFRAC);
   localparam logic [IW-1:0]        LAST_IDX = IW'(N_CH - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      UPDATE = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t state, state_n;

   logic [IW-1:0] idx;
   logic [RW-1:0] refrac [N_CH];

   logic signed [W-1:0]  v_cur;
   logic signed [W-1:0]  b_cur;
   logic signed [FW-1:0] v_ext;
   logic signed [FW-1:0] b_ext;
   logic signed [FW-1:0] sq;
   logic signed [FW-1:0] sum;
   logic [W-1:0]         v_sat;
   logic                 spike_hit;
   logic [RW-1:0]        refrac_cur;

   // ------------------------------------------------------------------
   // Sweep control
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE: begin
            if (step) begin
               state_n = UPDATE;
            end
         end
         UPDATE: begin
            if (idx == LAST_IDX) begin
               state_n = DONE;
            end
         end
         DONE: begin
            // step is deliberately not looked at here: a held step must not
            // chain straight into a new sweep without passing through IDLE.
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign busy = (state != IDLE);
   assign done = (state == DONE);

   // ------------------------------------------------------------------
   // Shared Euler datapath for the channel selected by idx
   // ------------------------------------------------------------------
   always_comb begin
      v_cur      = V[idx*W +: W];
      b_cur      = B[idx*W +: W];
      refrac_cur = refrac[idx];
      v_ext      = FW'(v_cur);
      b_ext      = FW'(b_cur);
      // The square is never negative, so the arithmetic shift is a plain divide.
      sq         = v_ext * v_ext;
      sum        = v_ext + (sq >>> SHIFT) + b_ext;
      spike_hit  = (sum >= PEAK_F);
      // Clamp instead of truncating so a large negative drive cannot wrap
      // the membrane around to a positive value.
      if (sum > MAX_F) begin
         v_sat = MAX_V;
      end else if (sum < MIN_F) begin
         v_sat = MIN_V;
      end else begin
         v_sat = sum[W-1:0];
      end
   end

   // ------------------------------------------------------------------
   // Channel state: membranes, refractory counters, spike flags, index
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         V         <= {N_CH{RESET_V}};
         spike_out <= '0;
         idx       <= '0;
         for (int i = 0; i < N_CH; i++) begin
            refrac[i] <= '0;
         end
      end else begin
         case (state)
            IDLE: begin
               if (step) begin
                  idx       <= '0;
                  spike_out <= '0;
               end
            end
            UPDATE: begin
               if (idx != LAST_IDX) begin
                  idx <= idx + 1'b1;
               end
               if (refrac_cur != '0) begin
                  // Frozen channel: membrane holds, only the counter moves.
                  refrac[idx] <= refrac_cur - 1'b1;
               end else if (spike_hit) begin
                  V[idx*W +: W]  <= RESET_V;
                  spike_out[idx] <= 1'b1;
                  refrac[idx]    <= REFRAC_V;
               end else begin
                  V[idx*W +: W] <= v_sat;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_qif_neuron_array.sv
// tb/tb_qif_neuron_array.sv - directed self-checking bench for qif_neuron_array

module tb_qif_neuron_array;

   localparam int N_CH = 4;
   localparam int W    = 8;

   logic              clk;
   logic              rst;
   logic              step;
   logic [N_CH*W-1:0] B;
   logic              busy;
   logic              done;
   logic [N_CH*W-1:0] V;
   logic [N_CH-1:0]   spike_out;

   int n_checks;
   int n_errors;

   qif_neuron_array #(
      .N_CH   (N_CH),
      .W      (W),
      .SHIFT  (3),
      .V_PEAK (64),
      .V_RESET(-16),
      .REFRAC (2)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .step     (step),
      .B        (B),
      .busy     (busy),
      .done     (done),
      .V        (V),
      .spike_out(spike_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("rst_v", V, 32'hF0F0F0F0);
      check("rst_spike", {28'd0, spike_out}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic sweep(input logic [31:0] b);
      int lat;
      @(negedge clk);
      B    = b;
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      check("busy_rise", {31'd0, busy}, 32'd1);
      lat = 0;
      while (done !== 1'b1 && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check("latency", lat, N_CH);
      @(posedge clk);
      #1;
      check("done_width", {31'd0, done}, 32'd0);
      check("idle_after", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      int ndone;
      n_checks = 0;
      n_errors = 0;
      rst  = 1'b0;
      step = 1'b0;
      B    = '0;

      // Power-on reset values
      #12;
      check("por_v", V, 32'hF0F0F0F0);
      check("por_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      // Basic sweep, then growth to spike and refractory hold
      sweep(32'h0);
      check("s1_v", V, 32'h10101010);
      check("s1_spk", {28'd0, spike_out}, 32'h0);
      sweep(32'h0);
      check("s2_v", V, 32'h30303030);
      sweep(32'h0);
      check("s3_v", V, 32'hF0F0F0F0);
      check("s3_spk", {28'd0, spike_out}, 32'hF);
      sweep(32'h0);
      check("ref1_v", V, 32'hF0F0F0F0);
      check("ref1_spk", {28'd0, spike_out}, 32'h0);
      sweep(32'h0);
      check("ref2_v", V, 32'hF0F0F0F0);
      sweep(32'h0);
      check("post_ref_v", V, 32'h10101010);

      // Asynchronous reset while idle with non-reset membranes
      do_reset();

      // Channel independence: lane 1 driven by -40
      sweep(32'h0000D800);
      check("ind1_v", V, 32'h1010E810);
      sweep(32'h0000D800);
      check("ind2_v", V, 32'h30300830);
      check("ind2_spk", {28'd0, spike_out}, 32'h0);

      // Negative saturation on lane 0: -4 + 2 - 128 = -130 clamps to -128
      do_reset();
      sweep(32'h000000EC);
      check("sat1_v", V, 32'h101010FC);
      sweep(32'h00000080);
      check("sat2_v", V, 32'h30303080);

      // Handshake abuse: step held through the sweep and the DONE cycle
      do_reset();
      @(negedge clk);
      B     = '0;
      step  = 1'b1;
      cyc   = 0;
      ndone = 0;
      do begin
         @(negedge clk);
         cyc++;
         if (done) ndone++;
      end while (!done && cyc < 20);
      check("abuse_latency", cyc, N_CH + 1);
      @(negedge clk);
      step = 1'b0;
      check("abuse_done_width", {31'd0, done}, 32'd0);
      check("abuse_idle", {31'd0, busy}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (done) ndone++;
      end
      check("abuse_one_done", ndone, 1);
      check("abuse_v", V, 32'h10101010);

      // Reset in the middle of a sweep, at idx = 2
      do_reset();
      @(negedge clk);
      B    = '0;
      step = 1'b1;
      @(posedge clk);
      #1;
      step = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("mid_partial_v", V, 32'hF0F01010);
      rst = 1'b0;
      #1;
      check("mid_rst_v", V, 32'hF0F0F0F0);
      check("mid_rst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk);
      rst = 1'b1;
      sweep(32'h0);
      check("mid_after_v", V, 32'h10101010);
      check("mid_after_spk", {28'd0, spike_out}, 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
